// File: rtl/db_b3gen8.sv
// db_b3gen8: byte-wide test-pattern source feeding the B3/PRBS checker.
// It frames a VC3/VC4/VT SPE and marks J1/V5 on each frame. In CEP mode it
// inserts the B3 BIP-8 or the V5 BIP-2 computed over the previous frame.
// Otherwise it emits a pure PRBS15 payload. Single-error injection is on demand.
module db_b3gen8 #(
    parameter bit          PKMOD    = 1'b0,
    parameter logic [14:0] PRBSSEED = 15'h7FFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfgcep,
    input  logic        cfgvc3,
    input  logic [12:0] cfgb3,
    input  logic        ifrst,
    input  logic        ien,
    input  logic        iinjerr,
    output logic        ovld,
    output logic [7:0]  odat,
    output logic        oj1,
    output logic        oinjdone
);

    logic [15:0] r_frmmax;
    logic [15:0] r_pos;
    logic [14:0] r_prbs;
    logic [7:0]  r_sum;
    logic [7:0]  r_prevsum;
    logic        r_pend;

    logic [15:0] w_frmmax;
    logic [15:0] w_pos_nxt;
    logic [14:0] w_prbs_nxt;
    logic [7:0]  w_sum_base;
    logic [7:0]  w_byte;
    logic [7:0]  w_out;
    logic [1:0]  w_fold;
    logic        w_j1;
    logic        w_b3sel;
    logic        w_v5sel;
    logic        w_tgt;
    logic        w_pend;
    logic        w_apply;

    // Frame length from the B3 position; unknown positions get the longest frame.
    always_comb begin
        case (cfgb3)
            13'd86:   w_frmmax = 16'd765;
            13'd88:   w_frmmax = 16'd783;
            13'd262:  w_frmmax = 16'd2349;
            13'd1045: w_frmmax = 16'd9396;
            default:  w_frmmax = 16'd37584;
        endcase
    end

    // PRBS15 advanced 8 steps; the first new bit lands in bit 7 of the byte.
    always_comb begin
        w_prbs_nxt = r_prbs;
        for (int i = 0; i < 8; i++) begin
            w_prbs_nxt = {w_prbs_nxt[13:0], w_prbs_nxt[14] ^ w_prbs_nxt[13]};
        end
    end

    // Position, byte selection, injection and running parity of the byte being sent.
    always_comb begin
        w_pos_nxt  = ((r_pos == 16'd0) || (r_pos >= r_frmmax) || ifrst) ? 16'd1 : r_pos + 16'd1;
        w_j1       = (w_pos_nxt == 16'd1);
        w_b3sel    = cfgcep & cfgvc3 & (w_pos_nxt == {3'b000, cfgb3});
        w_v5sel    = cfgcep & ~cfgvc3 & w_j1;
        // ifrst clears the running sum before the byte of the same cycle folds in
        w_sum_base = ifrst ? 8'h00 : r_sum;
        if (w_b3sel) begin
            w_byte = r_prevsum;
        end else if (w_v5sel) begin
            // the V5 byte carries the BIP-2 of the frame that just closed
            w_byte = {w_sum_base[1:0], w_prbs_nxt[5:0]};
        end else begin
            w_byte = w_prbs_nxt[7:0];
        end
        w_tgt   = cfgcep ? (w_b3sel | w_v5sel) : 1'b1;
        w_pend  = r_pend | iinjerr;
        w_apply = ien & w_tgt & w_pend;
        w_out   = w_byte;
        if (w_apply) begin
            w_out = w_byte ^ ((cfgcep & ~cfgvc3) ? 8'h40 : 8'h01);
        end
        w_fold = w_out[7:6] ^ w_out[5:4] ^ w_out[3:2] ^ w_out[1:0];
    end

    // Registered outputs and frame/PRBS/parity state, one byte per ien.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frmmax  <= 16'd783;
            r_pos     <= 16'd0;
            r_prbs    <= PRBSSEED;
            r_sum     <= 8'h00;
            r_prevsum <= 8'h00;
            r_pend    <= 1'b0;
            ovld      <= 1'b0;
            odat      <= 8'h00;
            oj1       <= 1'b0;
            oinjdone  <= 1'b0;
        end else begin
            r_frmmax <= w_frmmax;
            r_pend   <= w_apply ? 1'b0 : w_pend;
            ovld     <= ien;
            oj1      <= ien & w_j1 & ~PKMOD;
            oinjdone <= w_apply;
            if (ien) begin
                r_pos  <= w_pos_nxt;
                r_prbs <= w_prbs_nxt;
                odat   <= w_out;
                if (cfgvc3) begin
                    if (w_j1) begin
                        r_prevsum <= w_sum_base;
                        r_sum     <= w_out;
                    end else begin
                        r_sum     <= w_sum_base ^ w_out;
                    end
                end else begin
                    r_sum <= {w_sum_base[7:2], w_j1 ? w_fold : (w_sum_base[1:0] ^ w_fold)};
                end
            end else begin
                r_pos <= ifrst ? 16'd0 : r_pos;
                r_sum <= w_sum_base;
            end
        end
    end

endmodule

// File: tb/tb_db_b3gen8.sv
// Directed bench for db_b3gen8 with a byte-level scoreboard of the framed stream.
module tb_db_b3gen8;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        cfgcep  = 1'b0;
    logic        cfgvc3  = 1'b0;
    logic [12:0] cfgb3   = 13'd88;
    logic        ifrst   = 1'b0;
    logic        ien     = 1'b0;
    logic        iinjerr = 1'b0;
    logic        ovld;
    logic [7:0]  odat;
    logic        oj1;
    logic        oinjdone;

    int errs   = 0;
    int checks = 0;

    // scoreboard state
    logic [14:0] m_s;
    int          m_pos;
    logic [7:0]  m_acc;
    logic [7:0]  m_prev;
    logic        m_pend;

    db_b3gen8 #(.PKMOD(1'b0), .PRBSSEED(15'h7FFF)) dut (
        .clk(clk), .rst(rst), .cfgcep(cfgcep), .cfgvc3(cfgvc3), .cfgb3(cfgb3),
        .ifrst(ifrst), .ien(ien), .iinjerr(iinjerr),
        .ovld(ovld), .odat(odat), .oj1(oj1), .oinjdone(oinjdone)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic int m_max(input logic [12:0] b);
        case (b)
            13'd86:   return 765;
            13'd88:   return 783;
            13'd262:  return 2349;
            13'd1045: return 9396;
            default:  return 37584;
        endcase
    endfunction

    task automatic m_reset();
        m_s    = 15'h7FFF;
        m_pos  = 0;
        m_acc  = 8'h00;
        m_prev = 8'h00;
        m_pend = 1'b0;
    endtask

    // One clock of stimulus, then check the registered result against the scoreboard.
    task automatic step(input logic en, input logic fr, input logic inj, input string tag);
        logic [7:0] pb;
        logic [7:0] e;
        logic       tgt;
        logic       done;
        ien = en; ifrst = fr; iinjerr = inj;
        @(posedge clk); #1;
        ien = 1'b0; ifrst = 1'b0; iinjerr = 1'b0;
        done = 1'b0;
        if (inj) m_pend = 1'b1;
        if (fr) m_acc = 8'h00;
        if (!en) begin
            if (fr) m_pos = 0;
            chk1({tag, "_ovld_idle"}, ovld, 1'b0);
            chk1({tag, "_injdone_idle"}, oinjdone, 1'b0);
            return;
        end
        m_pos = (m_pos == 0 || m_pos >= m_max(cfgb3) || fr) ? 1 : m_pos + 1;
        for (int k = 0; k < 8; k++) m_s = {m_s[13:0], m_s[14] ^ m_s[13]};
        pb = m_s[7:0];
        if (m_pos == 1 && cfgvc3) m_prev = m_acc;
        if (cfgcep && cfgvc3 && m_pos == int'(cfgb3)) begin
            e = m_prev; tgt = 1'b1;
        end else if (cfgcep && !cfgvc3 && m_pos == 1) begin
            e = {m_acc[1:0], pb[5:0]}; tgt = 1'b1;
        end else begin
            e = pb; tgt = !cfgcep;
        end
        if (tgt && m_pend) begin
            e = e ^ ((cfgcep && !cfgvc3) ? 8'h40 : 8'h01);
            m_pend = 1'b0;
            done = 1'b1;
        end
        chk1({tag, "_ovld"}, ovld, 1'b1);
        chk8({tag, "_odat"}, odat, e);
        chk1({tag, "_oj1"}, oj1, m_pos == 1);
        chk1({tag, "_injdone"}, oinjdone, done);
        if (cfgvc3) m_acc = (m_pos == 1) ? e : (m_acc ^ e);
        else m_acc[1:0] = ((m_pos == 1) ? 2'b00 : m_acc[1:0]) ^ e[7:6] ^ e[5:4] ^ e[3:2] ^ e[1:0];
    endtask

    initial begin
        m_reset();
        // reset state
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("rst_ovld", ovld, 1'b0);
        chk8("rst_odat", odat, 8'h00);
        chk1("rst_oj1", oj1, 1'b0);
        chk1("rst_injdone", oinjdone, 1'b0);
        rst = 1'b1;

        // pure PRBS payload: first bytes 00, 02, J1 every 783 bytes
        cfgcep = 1'b0; cfgvc3 = 1'b0; cfgb3 = 13'd88;
        step(1'b1, 1'b0, 1'b0, "t1");
        chk8("t1_first_byte", odat, 8'h00);
        chk1("t1_first_j1", oj1, 1'b1);
        step(1'b1, 1'b0, 1'b0, "t1");
        chk8("t1_second_byte", odat, 8'h02);
        repeat (800) step(1'b1, 1'b0, 1'b0, "t1");
        // PRBS injection: second pending pulse absorbed, then same-cycle apply
        step(1'b0, 1'b0, 1'b1, "t1inj");
        step(1'b0, 1'b0, 1'b1, "t1inj");
        step(1'b1, 1'b0, 1'b0, "t1inj");
        chk1("t1inj_done", oinjdone, 1'b1);
        step(1'b1, 1'b0, 1'b0, "t1inj");
        step(1'b1, 1'b0, 1'b1, "t1inj_now");
        repeat (5) step(1'b1, 1'b0, 1'b0, "t1");

        // CEP STS, B3 at 88: frame 1 B3 is zero, later B3 = XOR of prior frame
        cfgcep = 1'b1; cfgvc3 = 1'b1; cfgb3 = 13'd88;
        step(1'b0, 1'b1, 1'b0, "t2");
        repeat (88) step(1'b1, 1'b0, 1'b0, "t2");
        chk8("t2_b3_frame1", odat, 8'h00);
        repeat (3 * 783 - 88 + 10) step(1'b1, 1'b0, 1'b0, "t2");

        // CEP STS injection mid-frame lands on the next B3, then feeds the next BIP
        step(1'b0, 1'b0, 1'b1, "t4");
        repeat (2 * 783) step(1'b1, 1'b0, 1'b0, "t4");

        // CEP VT, 765-byte frame: V5[7:6] carries BIP-2 of the prior frame
        cfgcep = 1'b1; cfgvc3 = 1'b0; cfgb3 = 13'd86;
        step(1'b0, 1'b1, 1'b0, "t3");
        step(1'b1, 1'b0, 1'b0, "t3");
        chk8("t3_v5_frame1_bip", odat & 8'hC0, 8'h00);
        repeat (3 * 765 + 10) step(1'b1, 1'b0, 1'b0, "t3");
        step(1'b0, 1'b0, 1'b1, "t3inj");
        repeat (2 * 765) step(1'b1, 1'b0, 1'b0, "t3inj");

        // STS with 50% ien and a frame restart at pos 400
        cfgcep = 1'b1; cfgvc3 = 1'b1; cfgb3 = 13'd88;
        step(1'b0, 1'b1, 1'b0, "t5");
        for (int n = 0; n < 1000 && m_pos != 399; n++) begin
            step(1'b1, 1'b0, 1'b0, "t5");
            step(1'b0, 1'b0, 1'b0, "t5");
        end
        chk1("t5_reached_399", m_pos == 399, 1'b1);
        step(1'b1, 1'b1, 1'b0, "t5_frst");
        chk1("t5_frst_j1", oj1, 1'b1);
        repeat (2 * 783 + 100) begin
            step(1'b0, 1'b0, 1'b0, "t5");
            step(1'b1, 1'b0, 1'b0, "t5");
        end

        // reset mid-frame at pos 300 restarts framing and PRBS
        for (int n = 0; n < 1000 && m_pos != 300; n++) step(1'b1, 1'b0, 1'b0, "t6");
        chk1("t6_reached_300", m_pos == 300, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_reset();
        chk1("t6_rst_ovld", ovld, 1'b0);
        chk8("t6_rst_odat", odat, 8'h00);
        chk1("t6_rst_oj1", oj1, 1'b0);
        step(1'b1, 1'b0, 1'b0, "t6");
        chk8("t6_first_byte", odat, 8'h00);
        chk1("t6_first_j1", oj1, 1'b1);
        step(1'b1, 1'b0, 1'b0, "t6");
        chk8("t6_second_byte", odat, 8'h02);
        repeat (100) step(1'b1, 1'b0, 1'b0, "t6");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
